// File: rtl/gate_sweep_sequencer_if.sv
// -----------------------------------------------------------------------------
// gate_sweep_sequencer_if
//
// Purpose: bundles the control, datapath and status signals of the gate sweep
// sequencer so the sequencer and its controller connect through one port.
//
// Signals (named from the sequencer's point of view):
//   i_start      sweep request (controller -> sequencer)
//   i_gate_y     6-bit gate datapath outputs {nand,nor,xor,or,and,not}
//   o_gate_a     drive to datapath input a
//   o_gate_b     drive to datapath input b
//   o_busy       sweep in progress
//   o_done       one-cycle end-of-sweep pulse
//   o_pass       all sampled bits matched the golden table
//   o_fail_mask  per-gate mismatch flags
//   o_result     captured responses, vector v at [6v+5:6v]
//
// Modports:
//   master  controller / datapath side (drives start and gate_y)
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface gate_sweep_sequencer_if;
  logic        i_start;
  logic [5:0]  i_gate_y;
  logic        o_gate_a;
  logic        o_gate_b;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [5:0]  o_fail_mask;
  logic [23:0] o_result;

  modport master (
    output i_start,
    output i_gate_y,
    input  o_gate_a,
    input  o_gate_b,
    input  o_busy,
    input  o_done,
    input  o_pass,
    input  o_fail_mask,
    input  o_result
  );

  modport slave (
    input  i_start,
    input  i_gate_y,
    output o_gate_a,
    output o_gate_b,
    output o_busy,
    output o_done,
    output o_pass,
    output o_fail_mask,
    output o_result
  );
endinterface

// File: rtl/gate_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// gate_sweep_sequencer
//
// Purpose: self-test sequencer for the two-input basic-gate datapath. On start
// it walks the four {a,b} vectors (a = vec[1], b = vec[0]), waits SETTLE
// cycles per vector, samples the six gate outputs and compares them against a
// built-in golden truth table. Reports captured responses, a per-gate fail
// mask and a pass flag.
//
// Parameters:
//   SETTLE   cycles from vector drive to sample, legal range 1..15 (default 2)
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   i_abort  abort an in-flight sweep (only when GATE_SEQ_ABORT_EN is defined)
//   bus      gate_sweep_sequencer_if.slave (start, gate_y, gate_a/b, busy,
//            done, pass, fail_mask, result)
//
// Optional feature macro: GATE_SEQ_ABORT_EN
//   Adds i_abort. Abort in DRIVE or SAMPLE returns to IDLE on the next edge,
//   clears gate_a/b and pass, keeps the fail mask accumulated so far and
//   suppresses done. Abort wins over the final SAMPLE.
// -----------------------------------------------------------------------------
module gate_sweep_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef GATE_SEQ_ABORT_EN
  input  logic i_abort,
`endif
  gate_sweep_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_vec;
  logic [3:0]  r_cnt;
  logic        r_gate_a;
  logic        r_gate_b;
  logic        r_pass;
  logic [5:0]  r_fail_mask;
  logic [23:0] r_result;

  logic        w_busy;
  logic        w_done;
  logic        w_abort;
  logic [5:0]  w_golden [4];
  logic [5:0]  w_mismatch;
  logic [5:0]  w_mask_acc;

  // Golden truth table built from the gate equations, one entry per vector.
  for (genvar gi = 0; gi < 4; gi++) begin : g_golden
    localparam logic [1:0] VEC = 2'(gi);
    assign w_golden[gi] = {~(VEC[1] & VEC[0]), ~(VEC[1] | VEC[0]),
                           VEC[1] ^ VEC[0], VEC[1] | VEC[0],
                           VEC[1] & VEC[0], ~VEC[1]};
  end

  assign w_mismatch = bus.i_gate_y ^ w_golden[r_vec];
  // Mask including the vector being sampled this cycle; used so pass can be
  // valid in the same cycle as done.
  assign w_mask_acc = r_fail_mask | w_mismatch;

`ifdef GATE_SEQ_ABORT_EN
  assign w_abort = i_abort && (r_state == S_DRIVE || r_state == S_SAMPLE);
`else
  assign w_abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (w_abort)             w_state_next = S_IDLE;
        else if (r_cnt == 4'd0)  w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_abort)             w_state_next = S_IDLE;
        else if (r_vec == 2'd3)  w_state_next = S_DONE;
        else                     w_state_next = S_DRIVE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_DRIVE, S_SAMPLE: w_busy = 1'b1;
      S_DONE:            w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: vector index, settle counter, drives and results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec       <= 2'd0;
      r_cnt       <= 4'd0;
      r_gate_a    <= 1'b0;
      r_gate_b    <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= 6'd0;
      r_result    <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_vec       <= 2'd0;
            r_cnt       <= CNT_INIT;
            r_gate_a    <= 1'b0;
            r_gate_b    <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 6'd0;
            r_result    <= 24'd0;
          end
        end
        S_DRIVE: begin
          if (w_abort) begin
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_pass   <= 1'b0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (w_abort) begin
            // Aborted sample is discarded; earlier mismatches are kept.
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_pass   <= 1'b0;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (r_vec == 2'(i)) r_result[6*i +: 6] <= bus.i_gate_y;
            end
            r_fail_mask <= w_mask_acc;
            if (r_vec == 2'd3) begin
              r_pass <= (w_mask_acc == 6'd0);
            end else begin
              r_vec                <= r_vec + 2'd1;
              {r_gate_a, r_gate_b} <= r_vec + 2'd1;
              r_cnt                <= CNT_INIT;
            end
          end
        end
        default: begin
          // DONE: results and drives hold.
        end
      endcase
    end
  end

  assign bus.o_gate_a    = r_gate_a;
  assign bus.o_gate_b    = r_gate_b;
  assign bus.o_busy      = w_busy;
  assign bus.o_done      = w_done;
  assign bus.o_pass      = r_pass;
  assign bus.o_fail_mask = r_fail_mask;
  assign bus.o_result    = r_result;

endmodule
